// File: rtl/booth_mac_pkg.sv
// Shared types for the radix-4 Booth multiply-accumulate sequencer.
// States, Booth digit bundle and digit-count helper.
package booth_mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        OUT
    } state_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic shift;
    } booth_digit_t;

    function automatic int digit_count(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/booth_mac_sequencer_if.sv
// Operand-in / result-out handshake bundle of the Booth MAC sequencer.
// master drives operands and consumes results; slave is the sequencer.
interface booth_mac_sequencer_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 24
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 busy;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/booth_digit_encoder.sv
// Radix-4 Booth recoder: bit triplet {b[2i+1], b[2i], b[2i-1]}
// to a digit in {-2,-1,0,+1,+2}.
module booth_digit_encoder
    import booth_mac_pkg::*;
(
    input  logic [2:0]   triplet,
    output booth_digit_t digit
);
    always_comb begin
        digit = '0;
        unique case (triplet)
            3'b000, 3'b111: digit.zero = 1'b1;
            3'b001, 3'b010: digit.neg  = 1'b0;
            3'b011:         digit.shift = 1'b1;
            3'b100: begin
                digit.neg   = 1'b1;
                digit.shift = 1'b1;
            end
            3'b101, 3'b110: digit.neg = 1'b1;
            default:        digit.zero = 1'b1;
        endcase
    end
endmodule

// File: rtl/booth_mac_sequencer.sv
// Multi-cycle signed MAC: one shared radix-4 Booth digit per cycle,
// accumulating a dot product released on the pair flagged last.
module booth_mac_sequencer
    import booth_mac_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 24
) (
    input logic                  clk,
    input logic                  rst,
    booth_mac_sequencer_if.slave bus
);
    localparam int N  = digit_count(WIDTH);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = WIDTH + 2;

    state_t               state_q;
    state_t               state_d;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 last_q;
    logic [ACC_WIDTH-1:0] acc_q;

    logic                 in_ready;
    logic                 in_fire;
    logic                 out_fire;
    logic                 last_digit;
    logic [WIDTH:0]       b_ext;
    logic [2:0]           triplet;
    booth_digit_t         digit;
    logic [AW-1:0]        a_ext;
    logic [AW-1:0]        mag;
    logic [AW-1:0]        pp;
    logic [ACC_WIDTH-1:0] pp_ext;
    logic [ACC_WIDTH-1:0] pp_sh;

    assign in_ready   = (state_q == IDLE) && !rst;
    assign in_fire    = bus.in_valid && in_ready;
    assign out_fire   = (state_q == OUT) && bus.out_ready;
    assign last_digit = (cnt_q == CW'(N - 1));

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = acc_q;
    assign bus.busy      = (state_q != IDLE);

    // b[-1] = 0 sits below the multiplier LSB
    assign b_ext = {b_q, 1'b0};

    always_comb begin
        triplet = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) triplet = b_ext[2*k +: 3];
        end
    end

    booth_digit_encoder u_enc (
        .triplet (triplet),
        .digit   (digit)
    );

    // two guard bits keep -2 * (-2^(WIDTH-1)) exact
    assign a_ext  = {{2{a_q[WIDTH-1]}}, a_q};
    assign mag    = digit.shift ? {a_ext[AW-2:0], 1'b0} : a_ext;
    assign pp     = digit.zero ? '0 : (digit.neg ? -mag : mag);
    assign pp_ext = {{(ACC_WIDTH-AW){pp[AW-1]}}, pp};
    assign pp_sh  = pp_ext << {cnt_q, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_fire) state_d = MUL;
            MUL:  if (last_digit) state_d = last_q ? OUT : IDLE;
            OUT:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            last_q <= 1'b0;
            acc_q  <= '0;
        end else begin
            if (in_fire) begin
                a_q    <= bus.in_a;
                b_q    <= bus.in_b;
                last_q <= bus.in_last;
                cnt_q  <= '0;
            end
            if (state_q == MUL) begin
                acc_q <= acc_q + pp_sh;
                cnt_q <= cnt_q + 1'b1;
            end
            if (out_fire) acc_q <= '0;
        end
    end
endmodule
